// File: rtl/mem_forward_unit.sv
// mem_forward_unit
//   MEM-stage store-data forwarding plus load-use hazard bubble insertion.
//
//   A DEPTH-entry history of recent forwardable register writebacks is kept.
//   A store in MEM takes the newest matching value from one of two places:
//   the live WB stage, or the history. Otherwise it uses the register-file
//   read it already carries. A two-state FSM raises a stall for exactly one
//   cycle per load-use hazard at ID/EX. It also counts stall cycles in a
//   saturating counter.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_freeze                global pipeline freeze, holds all state
//   i_wb_*                  writeback stage: valid, is_load, reg, data
//   i_mem_store/rt/rt_data  store in MEM and its pipelined source data
//   o_store_data            data sent to memory (forwarded or pass-through)
//   o_forward/o_forward_src forwarding active; 0 = live WB, k = history k-1
//   i_ex_load, i_ex_rt      load in EX and its destination register
//   i_id_rs/rt/uses_rt      source registers of the instruction in ID
//   o_load_use_stall        hold PC and IF/ID, bubble ID/EX
//   o_stall_count           saturating count of stall cycles
//   o_dbg_state             current FSM state (0 = IDLE, 1 = BUBBLE)
module mem_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2,
  parameter int FWD_ALL    = 0,
  parameter int SRC_W      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_freeze,
  input  logic                  i_wb_valid,
  input  logic                  i_wb_is_load,
  input  logic [REG_ADDR_W-1:0] i_wb_reg,
  input  logic [DATA_W-1:0]     i_wb_data,
  input  logic                  i_mem_store,
  input  logic [REG_ADDR_W-1:0] i_mem_rt,
  input  logic [DATA_W-1:0]     i_mem_rt_data,
  output logic [DATA_W-1:0]     o_store_data,
  output logic                  o_forward,
  output logic [SRC_W-1:0]      o_forward_src,
  input  logic                  i_ex_load,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  output logic                  o_load_use_stall,
  output logic [15:0]           o_stall_count,
  output logic                  o_dbg_state
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic                  hist_vld_q  [DEPTH];
  logic [REG_ADDR_W-1:0] hist_reg_q  [DEPTH];
  logic [DATA_W-1:0]     hist_data_q [DEPTH];

  logic                  wb_elig;
  logic                  detect;
  logic                  sel_hit;
  logic [SRC_W-1:0]      sel_src;
  logic [DATA_W-1:0]     sel_data;

  // Register 0 is hardwired, so a write to it never forwards anything.
  assign wb_elig = i_wb_valid && (i_wb_reg != '0) &&
                   ((FWD_ALL != 0) || i_wb_is_load);

  // Writeback history: entry 0 is the newest. Every unfrozen cycle shifts
  // in a new entry. An ineligible writeback shifts in an invalid entry, so
  // each value ages out after exactly DEPTH cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_vld_q[k]  <= 1'b0;
        hist_reg_q[k]  <= '0;
        hist_data_q[k] <= '0;
      end
    end else if (!i_freeze) begin
      hist_vld_q[0]  <= wb_elig;
      hist_reg_q[0]  <= i_wb_reg;
      hist_data_q[0] <= i_wb_data;
      for (int k = 1; k < DEPTH; k++) begin
        hist_vld_q[k]  <= hist_vld_q[k-1];
        hist_reg_q[k]  <= hist_reg_q[k-1];
        hist_data_q[k] <= hist_data_q[k-1];
      end
    end
  end

  // Forward select. The loop walks from oldest to newest so that the
  // youngest matching history entry wins. The live WB overrides the
  // history because it is newer still.
  always_comb begin
    sel_hit  = 1'b0;
    sel_src  = '0;
    sel_data = i_mem_rt_data;
    if (wb_elig && (i_wb_reg == i_mem_rt)) begin
      sel_hit  = 1'b1;
      sel_src  = '0;
      sel_data = i_wb_data;
    end else begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hist_vld_q[k] && (hist_reg_q[k] == i_mem_rt)) begin
          sel_hit  = 1'b1;
          sel_src  = SRC_W'(k + 1);
          sel_data = hist_data_q[k];
        end
      end
    end
  end

  assign o_forward     = i_mem_store && (i_mem_rt != '0) && sel_hit;
  assign o_store_data  = o_forward ? sel_data : i_mem_rt_data;
  assign o_forward_src = o_forward ? sel_src : '0;

  assign detect = i_ex_load && (i_ex_rt != '0) &&
                  ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  // In BUBBLE the hazard is already resolved: the load has moved on by one
  // stage. So detect is ignored and the machine always returns to IDLE.
  always_comb begin
    state_d          = state_q;
    o_load_use_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_load_use_stall = detect;
        if (detect && !i_freeze) state_d = ST_BUBBLE;
      end
      ST_BUBBLE: begin
        if (!i_freeze) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_load_use_stall && !i_freeze && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_mem_forward_unit.sv
module tb_mem_forward_unit;
  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int SW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          freeze, wb_valid, wb_is_load, mem_store;
  logic [RW-1:0] wb_reg, mem_rt, ex_rt, id_rs, id_rt;
  logic [DW-1:0] wb_data, mem_rt_data;
  logic          ex_load, id_uses_rt;

  // Index 0: FWD_ALL = 0, index 1: FWD_ALL = 1
  logic [DW-1:0] store_data [2];
  logic          fwd        [2];
  logic [SW-1:0] fsrc       [2];
  logic          stall      [2];
  logic [15:0]   cnt        [2];
  logic          dbg        [2];

  mem_forward_unit #(.REG_ADDR_W(RW), .DATA_W(DW), .DEPTH(DEPTH), .FWD_ALL(0), .SRC_W(SW)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_freeze(freeze),
    .i_wb_valid(wb_valid), .i_wb_is_load(wb_is_load), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
    .i_mem_store(mem_store), .i_mem_rt(mem_rt), .i_mem_rt_data(mem_rt_data),
    .o_store_data(store_data[0]), .o_forward(fwd[0]), .o_forward_src(fsrc[0]),
    .i_ex_load(ex_load), .i_ex_rt(ex_rt), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(id_uses_rt), .o_load_use_stall(stall[0]), .o_stall_count(cnt[0]),
    .o_dbg_state(dbg[0])
  );

  mem_forward_unit #(.REG_ADDR_W(RW), .DATA_W(DW), .DEPTH(DEPTH), .FWD_ALL(1), .SRC_W(SW)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_freeze(freeze),
    .i_wb_valid(wb_valid), .i_wb_is_load(wb_is_load), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
    .i_mem_store(mem_store), .i_mem_rt(mem_rt), .i_mem_rt_data(mem_rt_data),
    .o_store_data(store_data[1]), .o_forward(fwd[1]), .o_forward_src(fsrc[1]),
    .i_ex_load(ex_load), .i_ex_rt(ex_rt), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(id_uses_rt), .o_load_use_stall(stall[1]), .o_stall_count(cnt[1]),
    .o_dbg_state(dbg[1])
  );

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Recent-writeback list per instance, newest first: [0] = last cycle.
  bit            mv [2][DEPTH];
  logic [RW-1:0] mr [2][DEPTH];
  logic [DW-1:0] md [2][DEPTH];
  bit            m_bubble = 1'b0;  // last advancing cycle was a stall
  logic [15:0]   m_cnt = 16'd0;
  logic [15:0]   preload_val = 16'd0;
  int            preload_seq = 0;
  int            seen_seq = 0;

  function automatic bit m_elig(input int u);
    return wb_valid && (wb_reg != 0) && ((u == 1) || wb_is_load);
  endfunction

  function automatic bit m_detect();
    return ex_load && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic bit m_stall();
    return m_detect() && !m_bubble;
  endfunction

  function automatic logic [15:0] m_count();
    return (preload_seq != seen_seq) ? preload_val : m_cnt;
  endfunction

  task automatic m_fwd(input int u, output bit f, output logic [SW-1:0] s, output logic [DW-1:0] d);
    bit found;
    found = 1'b0;
    s = '0;
    d = mem_rt_data;
    if (m_elig(u) && (wb_reg == mem_rt)) begin
      found = 1'b1;
      d = wb_data;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && mv[u][k] && (mr[u][k] == mem_rt)) begin
          found = 1'b1;
          s = SW'(k + 1);
          d = md[u][k];
        end
      end
    end
    f = mem_store && (mem_rt != 0) && found;
    if (!f) begin
      s = '0;
      d = mem_rt_data;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_bubble <= 1'b0;
      m_cnt    <= 16'd0;
      seen_seq <= preload_seq;
      for (int u = 0; u < 2; u++)
        for (int k = 0; k < DEPTH; k++) mv[u][k] <= 1'b0;
    end else if (!freeze) begin
      m_bubble <= m_stall();
      m_cnt    <= (m_stall() && (m_count() != 16'hFFFF)) ? m_count() + 16'd1 : m_count();
      seen_seq <= preload_seq;
      for (int u = 0; u < 2; u++) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          mv[u][k] <= mv[u][k-1];
          mr[u][k] <= mr[u][k-1];
          md[u][k] <= md[u][k-1];
        end
        mv[u][0] <= m_elig(u);
        mr[u][0] <= wb_reg;
        md[u][0] <= wb_data;
      end
    end else begin
      m_cnt    <= m_count();
      seen_seq <= preload_seq;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit            ef;
    logic [SW-1:0] es;
    logic [DW-1:0] ed;
    #2;
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        m_fwd(u, ef, es, ed);
        check($sformatf("model_fwd_u%0d", u),   32'(fwd[u]),        32'(ef));
        check($sformatf("model_src_u%0d", u),   32'(fsrc[u]),       32'(es));
        check($sformatf("model_data_u%0d", u),  store_data[u],      ed);
        check($sformatf("model_stall_u%0d", u), 32'(stall[u]),      32'(m_stall()));
        check($sformatf("model_cnt_u%0d", u),   32'(cnt[u]),        32'(m_count()));
        check($sformatf("model_state_u%0d", u), 32'(dbg[u]),        32'(m_bubble));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk_fwd(input string name, input int u, input logic f, input logic [SW-1:0] s,
                         input logic [DW-1:0] d);
    check({name, "_fwd"},  32'(fwd[u]),  32'(f));
    check({name, "_src"},  32'(fsrc[u]), 32'(s));
    check({name, "_data"}, store_data[u], d);
  endtask

  task automatic chk_stall(input string name, input logic s, input logic [15:0] c);
    check({name, "_stall"}, 32'(stall[0]), 32'(s));
    check({name, "_cnt"},   32'(cnt[0]),   32'(c));
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0;
    wb_valid = 1'b0; wb_is_load = 1'b0; wb_reg = '0; wb_data = '0;
    mem_store = 1'b0; mem_rt = '0; mem_rt_data = '0;
    ex_load = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    repeat (2) nxt();

    // Reset state
    rst_n = 1'b1; chk_en = 1'b1;
    mem_store = 1'b1; mem_rt = 5'd5; mem_rt_data = 32'h77;
    #3;
    chk_fwd("reset", 0, 1'b0, 3'd0, 32'h77);
    chk_stall("reset", 1'b0, 16'd0);
    check("reset_state", 32'(dbg[0]), 32'd0);

    // Live WB load forwarding
    nxt();
    wb_valid = 1'b1; wb_is_load = 1'b1; wb_reg = 5'd5; wb_data = 32'hA5A5_0001; mem_rt_data = 32'h0;
    #3 chk_fwd("live_wb", 0, 1'b1, 3'd0, 32'hA5A5_0001);

    // History ageing for r7
    nxt(); wb_reg = 5'd7; wb_data = 32'h11; mem_rt = 5'd7; mem_rt_data = 32'hDEAD;
    #3 chk_fwd("r7_t", 0, 1'b1, 3'd0, 32'h11);
    nxt(); wb_data = 32'h22;
    #3 chk_fwd("r7_t1", 0, 1'b1, 3'd0, 32'h22);
    nxt(); wb_valid = 1'b0;
    #3 chk_fwd("r7_t2", 0, 1'b1, 3'd1, 32'h22);
    nxt();
    #3 chk_fwd("r7_t3", 0, 1'b1, 3'd2, 32'h22);
    nxt();
    #3 chk_fwd("r7_aged", 0, 1'b0, 3'd0, 32'hDEAD);

    // r0 and non-load eligibility
    nxt(); wb_valid = 1'b1; wb_is_load = 1'b1; wb_reg = 5'd0; wb_data = 32'h99;
    mem_rt = 5'd0; mem_rt_data = 32'h1234;
    #3; chk_fwd("r0_u0", 0, 1'b0, 3'd0, 32'h1234); chk_fwd("r0_u1", 1, 1'b0, 3'd0, 32'h1234);
    nxt(); wb_is_load = 1'b0; wb_reg = 5'd3; wb_data = 32'h33; mem_rt = 5'd3;
    #3; chk_fwd("nonload_u0", 0, 1'b0, 3'd0, 32'h1234); chk_fwd("nonload_u1", 1, 1'b1, 3'd0, 32'h33);
    nxt(); wb_valid = 1'b0;
    #3; chk_fwd("nonload_h_u0", 0, 1'b0, 3'd0, 32'h1234); chk_fwd("nonload_h_u1", 1, 1'b1, 3'd1, 32'h33);
    nxt(); mem_store = 1'b0;
    #3 chk_fwd("nostore_u1", 1, 1'b0, 3'd0, 32'h1234);

    // Load-use hazard, first stall cycle frozen
    nxt(); ex_load = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; freeze = 1'b1;
    #3 chk_stall("haz_frz", 1'b1, 16'd0);
    nxt(); freeze = 1'b0;
    #3; chk_stall("haz_a", 1'b1, 16'd0); check("haz_a_state", 32'(dbg[0]), 32'd0);
    nxt();
    #3; chk_stall("haz_b", 1'b0, 16'd1); check("haz_b_state", 32'(dbg[0]), 32'd1);
    nxt();
    #3 chk_stall("haz_c", 1'b1, 16'd1);
    nxt(); ex_load = 1'b0;
    #3 chk_stall("haz_done", 1'b0, 16'd2);
    nxt(); ex_load = 1'b1; ex_rt = 5'd6; id_rs = 5'd1; id_rt = 5'd6; id_uses_rt = 1'b0;
    #3 chk_stall("rt_unused", 1'b0, 16'd2);
    nxt(); id_uses_rt = 1'b1;
    #3 chk_stall("rt_used", 1'b1, 16'd2);
    nxt();
    #3 chk_stall("rt_bubble", 1'b0, 16'd3);
    nxt(); ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #3 chk_stall("r0_haz", 1'b0, 16'd3);
    nxt(); ex_load = 1'b0; id_uses_rt = 1'b0;

    // Saturation: counter placed near its limit
    nxt();
    force u_dut0.stall_cnt_q = 16'hFFFD;
    force u_dut1.stall_cnt_q = 16'hFFFD;
    preload_val = 16'hFFFD; preload_seq++;
    #1;
    release u_dut0.stall_cnt_q;
    release u_dut1.stall_cnt_q;
    #2 check("preload_cnt", 32'(cnt[0]), 32'hFFFD);
    nxt(); ex_load = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    #3 chk_stall("sat_a", 1'b1, 16'hFFFD);
    nxt(); #3 chk_stall("sat_b", 1'b0, 16'hFFFE);
    nxt(); #3 chk_stall("sat_c", 1'b1, 16'hFFFE);
    nxt(); #3 chk_stall("sat_d", 1'b0, 16'hFFFF);
    nxt(); #3 chk_stall("sat_e", 1'b1, 16'hFFFF);
    nxt(); #3 chk_stall("sat_f", 1'b0, 16'hFFFF);

    // Reset while in BUBBLE, with valid history and freeze asserted
    nxt(); wb_valid = 1'b1; wb_is_load = 1'b1; wb_reg = 5'd8; wb_data = 32'h88;
    #3 chk_stall("pre_rst", 1'b1, 16'hFFFF);
    nxt(); wb_valid = 1'b0; freeze = 1'b1; rst_n = 1'b0;
    mem_store = 1'b1; mem_rt = 5'd8; mem_rt_data = 32'h5555;
    #3; chk_fwd("in_rst", 0, 1'b1, 3'd1, 32'h88); check("in_rst_state", 32'(dbg[0]), 32'd1);
    nxt(); rst_n = 1'b1; freeze = 1'b0;
    #3;
    chk_fwd("post_rst", 0, 1'b0, 3'd0, 32'h5555);
    chk_stall("post_rst", 1'b1, 16'd0);
    check("post_rst_state", 32'(dbg[0]), 32'd0);
    nxt(); ex_load = 1'b0; mem_store = 1'b0;
    repeat (2) nxt();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
